// File: rtl/uart_rx.sv
// UART receive deserialiser: 2-flop input synchroniser, oversampled start/data/stop
// framing on the shared baud Tick strobe, right-aligned word output with framing-error flag.
module uart_rx #(
    parameter int OVS = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       Rx,
    input  logic [3:0] NBits,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [1:0]    sync_reg;
    logic          rx_s;

    state_t        state_reg, state_next;
    logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [3:0]    nb_reg, nb_next;
    logic [7:0]    sr_reg, sr_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic          frame_err_reg, frame_err_next;
    logic          rx_done_reg, rx_done_next;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], Rx};
        end
    end

    assign rx_s = sync_reg[1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            nb_reg        <= 4'd8;
            sr_reg        <= '0;
            rx_data_reg   <= '0;
            frame_err_reg <= 1'b0;
            rx_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            nb_reg        <= nb_next;
            sr_reg        <= sr_next;
            rx_data_reg   <= rx_data_next;
            frame_err_reg <= frame_err_next;
            rx_done_reg   <= rx_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        nb_next        = nb_reg;
        sr_next        = sr_reg;
        rx_data_next   = rx_data_reg;
        frame_err_next = frame_err_reg;
        rx_done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Tick && !rx_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                    sr_next       = '0;
                    nb_next       = (NBits >= 4'd5 && NBits <= 4'd8) ? NBits : 4'd8;
                end
            end

            START: begin
                if (Tick) begin
                    if (tick_cnt_reg == TICK_MID) begin
                        // A start bit that is high again at mid-bit is treated as a glitch.
                        if (!rx_s) begin
                            state_next    = DATA;
                            tick_cnt_next = '0;
                            bit_cnt_next  = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end

            DATA: begin
                if (Tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        sr_next       = {rx_s, sr_reg[7:1]};
                        tick_cnt_next = '0;
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'(nb_reg - 4'd1)) begin
                            state_next = STOP;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end

            STOP: begin
                if (Tick) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        // Short words were shifted in from the top; realign to bit 0.
                        rx_data_next   = sr_reg >> (4'd8 - nb_reg);
                        frame_err_next = ~rx_s;
                        rx_done_next   = 1'b1;
                        tick_cnt_next  = '0;
                        state_next     = IDLE;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign RxData   = rx_data_reg;
    assign RxDone   = rx_done_reg;
    assign FrameErr = frame_err_reg;
    assign Busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected words into a queue,
// an independent monitor pops and compares on every RxDone pulse.
module tb_uart_rx;

    localparam int OVS = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tick = 1'b0;
    logic       Rx = 1'b1;
    logic [3:0] NBits = 4'd8;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;

    int         total = 0;
    int         bad = 0;
    int         done_seen = 0;
    bit         jit_en = 1'b0;
    logic       prev_done = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;

    uart_rx #(.OVS(OVS)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .Rx       (Rx),
        .NBits    (NBits),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Minimum gap of 2 Clk lets a new Rx level clear the synchroniser before the Tick.
    task automatic tick();
        int gap;
        gap = 2 + (jit_en ? int'($urandom_range(0, 3)) : 0);
        repeat (gap) @(negedge Clk);
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (OVS) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic stop_bit,
                              input logic [3:0] nb_mid);
        send_bit(1'b0);
        NBits = nb_mid;
        for (int i = 0; i < n; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    always @(negedge Clk) begin
        if (RxDone) begin
            done_seen++;
            check("rxdone_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rxdone: got data %0h ferr %0b expected no pulse",
                         RxData, FrameErr);
            end else begin
                exp_e = exp_q.pop_front();
                check("rxdata", {24'd0, RxData}, {24'd0, exp_e[8:1]});
                check("frameerr", {31'd0, FrameErr}, {31'd0, exp_e[0]});
                $display("frame: data=%02h ferr=%0b expected data=%02h ferr=%0b",
                         RxData, FrameErr, exp_e[8:1], exp_e[0]);
            end
        end
        prev_done = RxDone;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_rxdata", {24'd0, RxData}, 32'd0);
        check("rst_rxdone", {31'd0, RxDone}, 32'd0);
        check("rst_frameerr", {31'd0, FrameErr}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // T1: plain 8N1 frame
        exp_q.push_back({8'hA5, 1'b0});
        send_frame(8'hA5, 8, 1'b1, 4'd8);
        check("t1_busy_after", {31'd0, Busy}, 32'd0);

        // T2: one-tick glitch aborts at mid start bit
        Rx = 1'b0;
        tick();
        check("t2_busy_tick1", {31'd0, Busy}, 32'd1);
        Rx = 1'b1;
        tick();
        check("t2_busy_tick2", {31'd0, Busy}, 32'd1);
        tick();
        check("t2_busy_tick3", {31'd0, Busy}, 32'd0);
        send_bit(1'b1);

        // T3: low stop bit, then idle bit to let the spurious start abort, then good frame
        exp_q.push_back({8'h3C, 1'b1});
        send_frame(8'h3C, 8, 1'b0, 4'd8);
        send_bit(1'b1);
        exp_q.push_back({8'h81, 1'b0});
        send_frame(8'h81, 8, 1'b1, 4'd8);

        // T4: 5-bit word (NBits change mid-frame ignored), then NBits=0 as 8
        NBits = 4'd5;
        exp_q.push_back({8'h15, 1'b0});
        send_frame(8'h15, 5, 1'b1, 4'd8);
        NBits = 4'd0;
        exp_q.push_back({8'hFF, 1'b0});
        send_frame(8'hFF, 8, 1'b1, 4'd0);

        // T5: reset in the middle of data bit 4 of 0x55
        NBits = 4'd8;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        Rx = 1'b1;
        tick();
        tick();
        check("t5_busy_before_rst", {31'd0, Busy}, 32'd1);
        Rst = 1'b1;
        #1;
        check("t5_rst_rxdata", {24'd0, RxData}, 32'd0);
        check("t5_rst_rxdone", {31'd0, RxDone}, 32'd0);
        check("t5_rst_frameerr", {31'd0, FrameErr}, 32'd0);
        check("t5_rst_busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        send_bit(1'b1);
        exp_q.push_back({8'hC3, 1'b0});
        send_frame(8'hC3, 8, 1'b1, 4'd8);

        // T6: back-to-back frames with jittered Tick
        jit_en = 1'b1;
        exp_q.push_back({8'h01, 1'b0});
        exp_q.push_back({8'h80, 1'b0});
        exp_q.push_back({8'h7E, 1'b0});
        send_frame(8'h01, 8, 1'b1, 4'd8);
        send_frame(8'h80, 8, 1'b1, 4'd8);
        send_frame(8'h7E, 8, 1'b1, 4'd8);
        jit_en = 1'b0;

        repeat (20) @(negedge Clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("rxdone_count", done_seen, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
